// File: rtl/piso_y_pkg.sv
// Shared sizing for the Y (result) unloader: the same DATA_WIDTH / PE_NUM /
// PE_ADDR_WIDTH values the X SIPO loader is built with, plus a small helper
// used by the drain counter.
package piso_y_pkg;

    // Width of one real or imaginary component.
    localparam int DATA_WIDTH    = 16;
    // Number of PEs, i.e. complex words per result vector (>= 2).
    localparam int PE_NUM        = 8;
    // Word index width, clog2(PE_NUM).
    localparam int PE_ADDR_WIDTH = 3;

    // The drain counter wraps on an explicit compare rather than on overflow,
    // so PE_NUM does not have to be a power of two.
    function automatic logic is_last_word(input logic [PE_ADDR_WIDTH-1:0] cnt,
                                          input int                       pe_num);
        return cnt == PE_ADDR_WIDTH'(pe_num - 1);
    endfunction

endpackage

// File: rtl/piso_y_if.sv
// Handshake bundle for the Y unloader: parallel capture side from the PE array
// and serial word stream towards downstream.
// Ports: p_valid/p_ready/p_in (vector in), s_valid/s_ready/s_data/s_last (words out).
interface piso_y_if #(
    parameter int DATA_WIDTH = 16,
    parameter int PE_NUM     = 8
);
    // Parallel side: PE i occupies p_in[(i+1)*2*DATA_WIDTH-1 : i*2*DATA_WIDTH].
    logic                           p_valid;
    logic                           p_ready;
    logic [PE_NUM*2*DATA_WIDTH-1:0] p_in;

    // Serial side: one complex word per transfer, PE 0 first.
    logic                           s_valid;
    logic                           s_ready;
    logic [2*DATA_WIDTH-1:0]        s_data;
    logic                           s_last;

    // Environment view: drives vectors in and accepts words out.
    modport master (
        output p_valid,
        output p_in,
        output s_ready,
        input  p_ready,
        input  s_valid,
        input  s_data,
        input  s_last
    );

    // Unloader view.
    modport slave (
        input  p_valid,
        input  p_in,
        input  s_ready,
        output p_ready,
        output s_valid,
        output s_data,
        output s_last
    );

endinterface

// File: rtl/piso_y_bank.sv
// One PE_NUM-word capture register with a load enable and a word-index read mux.
// Latency: load visible on rd_word the cycle after the load edge; read mux is combinational.
// Backpressure: none here; the parent decides when a load is allowed.
// Ports: clk, load, p_in (whole vector), rd_idx (word select), rd_word (selected word).
module piso_y_bank #(
    parameter int DATA_WIDTH    = 16,
    parameter int PE_NUM        = 8,
    parameter int PE_ADDR_WIDTH = 3
) (
    input  logic                           clk,
    input  logic                           load,
    input  logic [PE_NUM*2*DATA_WIDTH-1:0] p_in,
    input  logic [PE_ADDR_WIDTH-1:0]       rd_idx,
    output logic [2*DATA_WIDTH-1:0]        rd_word
);

    localparam int WORD_WIDTH = 2 * DATA_WIDTH;

    // Data storage only; validity lives in the parent's full flags, so the
    // contents deliberately carry no reset.
    logic [WORD_WIDTH-1:0] words [PE_NUM];

    always_ff @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < PE_NUM; i++) begin
                words[i] <= p_in[i*WORD_WIDTH +: WORD_WIDTH];
            end
        end
    end

    // rd_idx never exceeds PE_NUM-1 because the parent wraps it explicitly.
    assign rd_word = words[rd_idx];

endmodule

// File: rtl/piso_y.sv
// Ping-pong parallel-in serial-out unloader for PE array result vectors (Y path).
// Latency: a captured vector offers word 0 the cycle after capture when its buffer is next to drain.
// Backpressure: p_ready drops when both buffers are full; s_ready low holds s_data/s_last stable.
// Ports: clk, rst_n (sync, active low), bus (piso_y_if.slave: p_*/s_* handshakes), busy.
module piso_y
    import piso_y_pkg::*;
#(
    parameter int DATA_WIDTH    = piso_y_pkg::DATA_WIDTH,
    parameter int PE_NUM        = piso_y_pkg::PE_NUM,
    parameter int PE_ADDR_WIDTH = piso_y_pkg::PE_ADDR_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    piso_y_if.slave   bus,
    output logic      busy
);

    localparam int WORD_WIDTH = 2 * DATA_WIDTH;

    // Registered control state.
    logic [1:0]               full;      // per-buffer "holds an undrained vector"
    logic                     wr_sel;    // buffer the next capture goes into
    logic                     rd_sel;    // buffer currently draining
    logic [PE_ADDR_WIDTH-1:0] word_cnt;  // word of rd_sel being offered

    logic                     p_ready_i;
    logic                     s_valid_i;
    logic                     p_fire;
    logic                     s_fire;
    logic                     at_last;
    logic [1:0]               bank_load;
    logic [WORD_WIDTH-1:0]    bank_word [2];

    // Handshake outputs depend on registered state (and rst_n) only, so there
    // is no combinational path from s_ready to p_ready. rst_n gates them so
    // the outputs are quiet for the whole reset window, not just after the
    // first reset edge.
    assign p_ready_i = rst_n & ~full[wr_sel];
    assign s_valid_i = rst_n &  full[rd_sel];

    assign p_fire  = bus.p_valid & p_ready_i;
    assign s_fire  = s_valid_i & bus.s_ready;
    assign at_last = is_last_word(word_cnt, PE_NUM);

    // Capture only ever targets an empty buffer and drain only a full one, so
    // a same-edge capture and release always touch different full bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full     <= 2'b00;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            word_cnt <= '0;
        end else begin
            if (p_fire) begin
                full[wr_sel] <= 1'b1;
                wr_sel       <= ~wr_sel;
            end
            if (s_fire) begin
                if (at_last) begin
                    word_cnt     <= '0;
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
        end
    end

    // Two identical banks; each loads only when it is the capture target.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_load[b] = p_fire & (wr_sel == 1'(b));

        piso_y_bank #(
            .DATA_WIDTH    (DATA_WIDTH),
            .PE_NUM        (PE_NUM),
            .PE_ADDR_WIDTH (PE_ADDR_WIDTH)
        ) u_bank (
            .clk     (clk),
            .load    (bank_load[b]),
            .p_in    (bus.p_in),
            .rd_idx  (word_cnt),
            .rd_word (bank_word[b])
        );
    end

    assign bus.p_ready = p_ready_i;
    assign bus.s_valid = s_valid_i;
    // Zero the data bus when idle so stale buffer contents never leak out.
    assign bus.s_data  = s_valid_i ? bank_word[rd_sel] : '0;
    assign bus.s_last  = s_valid_i & at_last;
    assign busy        = rst_n & (full[0] | full[1]);

endmodule

// File: tb/tb_piso_y.sv
module tb_piso_y;
    import piso_y_pkg::*;

    localparam int DW = piso_y_pkg::DATA_WIDTH;
    localparam int N  = piso_y_pkg::PE_NUM;
    localparam int WW = 2 * DW;
    localparam int VW = N * WW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    piso_y_if #(.DATA_WIDTH(DW), .PE_NUM(N)) bus();

    piso_y dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    // Reference model: a count of vectors held (accepted, last word not yet
    // taken) and the queue of words still owed downstream, in order.
    typedef struct {
        logic [WW-1:0] d;
        logic          l;
    } exp_t;

    exp_t q[$];
    int   occ   = 0;
    int   total = 0;
    int   bad   = 0;
    logic exp_pr;
    logic exp_sv;

    logic sr_manual = 1'b0;
    logic rnd_sr    = 1'b0;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Monitor: sample mid-cycle, compare, then advance the model across the
    // coming rising edge using its own expectations, never the DUT's.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_p_ready", WW'(bus.p_ready), '0);
            chk("rst_s_valid", WW'(bus.s_valid), '0);
            chk("rst_s_data",  bus.s_data,       '0);
            chk("rst_s_last",  WW'(bus.s_last),  '0);
            chk("rst_busy",    WW'(busy),        '0);
            occ = 0;
            q.delete();
        end else begin
            exp_pr = (occ < 2);
            exp_sv = (occ > 0);
            chk("p_ready", WW'(bus.p_ready), WW'(exp_pr));
            chk("s_valid", WW'(bus.s_valid), WW'(exp_sv));
            chk("busy",    WW'(busy),        WW'(exp_sv));
            if (exp_sv && q.size() > 0) begin
                chk("s_data", bus.s_data,      q[0].d);
                chk("s_last", WW'(bus.s_last), WW'(q[0].l));
                if (bus.s_ready) begin
                    if (q[0].l) occ--;
                    void'(q.pop_front());
                end
            end else begin
                chk("idle_s_data", bus.s_data,      '0);
                chk("idle_s_last", WW'(bus.s_last), '0);
            end
            if (bus.p_valid && exp_pr) begin
                for (int i = 0; i < N; i++) begin
                    exp_t e;
                    e.d = bus.p_in[i*WW +: WW];
                    e.l = (i == N - 1);
                    q.push_back(e);
                end
                occ++;
            end
        end
    end

    // s_ready driver: random when enabled, otherwise follows sr_manual.
    // Applied at +2 so main-sequence updates at +1 land in the same cycle.
    always @(posedge clk) begin
        #2;
        bus.s_ready = rnd_sr ? 1'($urandom_range(0, 1)) : sr_manual;
    end

    function automatic logic [VW-1:0] mk_vec(input logic [WW-1:0] base);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*WW +: WW] = base + WW'(i);
        return v;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i*WW +: WW] = WW'($urandom);
        return v;
    endfunction

    // Offer a vector from posedge+1 until the DUT accepts it; returns at the
    // posedge+1 following the accepting edge with p_valid dropped.
    task automatic send_vec(input logic [VW-1:0] v);
        bit ok;
        ok = 0;
        bus.p_in    = v;
        bus.p_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.p_ready) ok = 1;
            @(posedge clk);
            #1;
        end
        bus.p_valid = 1'b0;
        if (!ok) timeout_fail("send_vec");
    endtask

    task automatic wait_drain(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (occ == 0) ok = 1;
        end
        if (!ok) timeout_fail("wait_drain");
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.p_valid = 1'b0;
        bus.p_in    = '0;
        bus.s_ready = 1'b0;

        // Reset with p_valid asserted: nothing may be accepted.
        sr_manual   = 1'b1;
        bus.p_valid = 1'b1;
        bus.p_in    = mk_vec(32'h5500_0000);
        repeat (3) @(posedge clk);
        #1;
        bus.p_valid = 1'b0;
        rst_n       = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Single vector, s_ready high.
        send_vec(mk_vec(32'hA000_0000));
        wait_drain(50);

        // Back-to-back vectors drain as 16 contiguous words.
        send_vec(mk_vec(32'hA000_0000));
        send_vec(mk_vec(32'hB000_0000));
        wait_drain(50);

        // Backpressure on word 3 for 5 cycles.
        sr_manual = 1'b0;
        @(posedge clk);
        #1;
        send_vec(mk_vec(32'hA000_0000));
        sr_manual = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sr_manual = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        sr_manual = 1'b1;
        wait_drain(50);

        // Full stall: third vector waits until the first fully drains.
        sr_manual = 1'b0;
        @(posedge clk);
        #1;
        send_vec(mk_vec(32'hA000_0000));
        send_vec(mk_vec(32'hB000_0000));
        fork
            send_vec(mk_vec(32'hC000_0000));
            begin
                repeat (3) @(posedge clk);
                #1;
                sr_manual = 1'b1;
            end
        join
        wait_drain(80);

        // Reset mid-drain with a second vector queued, then a clean vector.
        sr_manual = 1'b0;
        @(posedge clk);
        #1;
        send_vec(mk_vec(32'hA000_0000));
        send_vec(mk_vec(32'hB000_0000));
        sr_manual = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        send_vec(mk_vec(32'hC000_0000));
        wait_drain(50);

        // Random data, random gaps, random s_ready.
        rnd_sr = 1'b1;
        for (int k = 0; k < 40; k++) begin
            send_vec(rnd_vec());
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        wait_drain(3000);
        rnd_sr = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
